rs_encoder_seq: RTL and testbench

//  Sequential systematic RS(15,9) encoder over GF(16), field poly x^4+x+1, alpha=4'b0010.

---
 rtl/rs15_9_pkg.sv | 41 ++++
 rtl/rs_lfsr6.sv | 45 ++++
 rtl/rs_encoder_seq.sv | 107 ++++++++++
 tb/tb_rs_encoder_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs15_9_pkg.sv
// Shared definitions for the RS(15,9) link over GF(16), field polynomial x^4+x+1.
// Holds the code geometry, the generator polynomial coefficients, the encoder
// state encoding and the GF(16) multiply used by both the encoder and the decoder.
package rs15_9_pkg;

  localparam int SYM_W   = 4;
  localparam int N_SYM   = 15;
  localparam int K_SYM   = 9;
  localparam int PAR_SYM = N_SYM - K_SYM;
  localparam int CNT_W   = 4;

  // x^4 = x + 1, so an overflowing shift folds back in as 4'b0011.
  localparam logic [SYM_W-1:0] FIELD_POLY = 4'b0011;

  // g(x) = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C; element [i] is the x^i
  // coefficient, and the monic x^6 term is implicit.
  localparam logic [PAR_SYM-1:0][SYM_W-1:0] GEN_COEF =
    {4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } enc_state_t;

  // Shift-and-add GF(16) multiply: walk b's bits LSB first while a is
  // repeatedly multiplied by x and reduced.
  function automatic logic [SYM_W-1:0] gf16_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] shifted;
    acc     = '0;
    shifted = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ shifted;
      shifted = {shifted[SYM_W-2:0], 1'b0} ^ (shifted[SYM_W-1] ? FIELD_POLY : '0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_lfsr6.sv
// Six-stage parity register that divides m(x)*x^6 by g(x), one symbol per clock.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears all stages
//   sym    - message symbol fed this cycle, highest degree first
//   en     - advance the division by one symbol
//   clr    - synchronous clear of all stages (takes priority over en)
//   parity - {p5, p4, p3, p2, p1, p0}, p5 in the top symbol
import rs15_9_pkg::*;

module rs_lfsr6 (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SYM_W-1:0]           sym,
  input  logic                       en,
  input  logic                       clr,
  output logic [PAR_SYM*SYM_W-1:0]   parity
);

  logic [PAR_SYM-1:0][SYM_W-1:0] stage;
  logic [SYM_W-1:0]              fb;

  // Feedback is the incoming symbol plus the leading remainder coefficient.
  always_comb begin
    fb = sym ^ stage[PAR_SYM-1];
  end

  // Each stage takes its lower neighbour plus fb scaled by its generator
  // coefficient; the bottom stage has no neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (clr) begin
      stage <= '0;
    end else if (en) begin
      stage[0] <= gf16_mul(fb, GEN_COEF[0]);
      for (int i = 1; i < PAR_SYM; i++) begin
        stage[i] <= stage[i-1] ^ gf16_mul(fb, GEN_COEF[i]);
      end
    end
  end

  assign parity = stage;

endmodule

// File: rtl/rs_encoder_seq.sv
// Sequential systematic RS(15,9) encoder. A rising edge on encodeMessage latches
// the message, nine clocks of LFSR division produce the parity, and one more
// clock publishes {message, parity} together with a one-cycle done pulse.
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-high reset, aborts any encode
//   messageIn     - 9 message symbols, symbol k at [4k+:4]
//   encodeMessage - request; only its rising edge starts an encode
//   codeWordOut   - 15 codeword symbols, symbol i is the x^i coefficient
//   encoderBusy   - high from the accepted request until the result is out
//   encodeDone    - one-cycle pulse when codeWordOut changes
import rs15_9_pkg::*;

module rs_encoder_seq (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [K_SYM*SYM_W-1:0]   messageIn,
  input  logic                     encodeMessage,
  output logic [N_SYM*SYM_W-1:0]   codeWordOut,
  output logic                     encoderBusy,
  output logic                     encodeDone
);

  enc_state_t                  state;
  enc_state_t                  next_state;
  logic                        prev_req;
  logic                        req_edge;
  logic [CNT_W-1:0]            cnt;
  logic [K_SYM*SYM_W-1:0]      msg_reg;
  logic [K_SYM-1:0][SYM_W-1:0] msg_sym;
  logic [PAR_SYM*SYM_W-1:0]    parity;
  logic                        load;
  logic                        shift_en;
  logic                        finish;

  assign req_edge = encodeMessage & ~prev_req;
  assign msg_sym  = msg_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Edges arriving outside IDLE are simply not looked at, so they are dropped.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req_edge) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The load cycle also clears the parity so a fresh division starts from zero.
  rs_lfsr6 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .sym    (msg_sym[cnt]),
    .en     (shift_en),
    .clr    (load),
    .parity (parity)
  );

  // Request history, message latch, symbol counter and the published result.
  // The counter walks from the top message symbol down to symbol 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_req    <= 1'b0;
      msg_reg     <= '0;
      cnt         <= '0;
      encoderBusy <= 1'b0;
      encodeDone  <= 1'b0;
      codeWordOut <= '0;
    end else begin
      prev_req   <= encodeMessage;
      encodeDone <= finish;
      if (load) begin
        msg_reg     <= messageIn;
        cnt         <= CNT_W'(K_SYM - 1);
        encoderBusy <= 1'b1;
      end
      if (shift_en && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        codeWordOut <= {msg_reg, parity};
        encoderBusy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_encoder_seq.sv
// Self-checking bench for rs_encoder_seq. The reference encoder builds g(x)
// from its roots and does textbook polynomial long division with log/antilog
// GF(16) arithmetic; codewords are also checked to vanish at alpha^1..alpha^6.
module tb_rs_encoder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] messageIn;
  logic        encodeMessage;
  logic [59:0] codeWordOut;
  logic        encoderBusy;
  logic        encodeDone;

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;

  int gf_exp [0:14];
  int gf_log [0:15];
  int gen    [0:6];

  rs_encoder_seq dut (
    .clk           (clk),
    .rst           (rst),
    .messageIn     (messageIn),
    .encodeMessage (encodeMessage),
    .codeWordOut   (codeWordOut),
    .encoderBusy   (encoderBusy),
    .encodeDone    (encodeDone)
  );

  always #5 clk = ~clk;

  // Count every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (encodeDone) done_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int gfMul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gf_exp[(gf_log[a] + gf_log[b]) % 15];
  endfunction

  // Antilog table by repeated multiplication by alpha, then g(x) as the
  // product of (x + alpha^i) for i = 1..6.
  task automatic buildModel();
    int v;
    gf_exp[0] = 1;
    gf_log[0] = 0;
    for (int i = 1; i < 15; i++) begin
      v = gf_exp[i-1] << 1;
      if ((v & 16) != 0) v = v ^ 19;
      gf_exp[i] = v;
    end
    for (int i = 0; i < 15; i++) gf_log[gf_exp[i]] = i;
    for (int d = 0; d < 7; d++) gen[d] = 0;
    gen[0] = 1;
    for (int i = 1; i <= 6; i++) begin
      for (int d = i; d >= 0; d--) begin
        gen[d] = ((d > 0) ? gen[d-1] : 0) ^ gfMul(gen[d], gf_exp[i]);
      end
    end
  endtask

  function automatic logic [59:0] refEncode(input logic [35:0] m);
    int r [0:14];
    int c;
    logic [59:0] cw;
    for (int i = 0; i < 15; i++) r[i] = 0;
    for (int i = 0; i < 9; i++) r[i+6] = int'(m[4*i +: 4]);
    for (int deg = 14; deg >= 6; deg--) begin
      c = r[deg];
      if (c != 0) begin
        for (int j = 0; j <= 6; j++) r[deg-6+j] = r[deg-6+j] ^ gfMul(c, gen[j]);
      end
    end
    cw[59:24] = m;
    for (int i = 0; i < 6; i++) cw[4*i +: 4] = 4'(r[i]);
    return cw;
  endfunction

  // Number of roots alpha^1..alpha^6 at which the codeword does not vanish.
  function automatic int badSyndromes(input logic [59:0] cw);
    int s;
    int bad;
    bad = 0;
    for (int j = 1; j <= 6; j++) begin
      s = 0;
      for (int i = 0; i < 15; i++) s = s ^ gfMul(int'(cw[4*i +: 4]), gf_exp[(i*j) % 15]);
      if (s != 0) bad++;
    end
    return bad;
  endfunction

  // One request pulse, bounded wait for done, latency and pulse-width checks.
  task automatic applyStimulus(input logic [35:0] msg, output logic [59:0] cw);
    int k;
    @(posedge clk); #1;
    messageIn     = msg;
    encodeMessage = 1'b1;
    @(posedge clk); #1;
    encodeMessage = 1'b0;
    checkOutput("busy_after_E0", 64'(encoderBusy), 64'd1);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (encodeDone) break;
    end
    checkOutput("latency", 64'(k), 64'd10);
    checkOutput("busy_at_done", 64'(encoderBusy), 64'd0);
    cw = codeWordOut;
    @(posedge clk); #1;
    checkOutput("done_width", 64'(encodeDone), 64'd0);
  endtask

  logic [35:0] ma;
  logic [35:0] mb;
  logic [59:0] ca;
  logic [59:0] cb;
  logic [59:0] cab;
  int          pulses_before;

  initial begin
    buildModel();
    rst           = 1'b1;
    messageIn     = '0;
    encodeMessage = 1'b0;
    #12;
    checkOutput("reset_cw", 64'(codeWordOut), 64'd0);
    checkOutput("reset_busy", 64'(encoderBusy), 64'd0);
    checkOutput("reset_done", 64'(encodeDone), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(36'h0, ca);
    checkOutput("zero_msg", 64'(ca), 64'd0);

    applyStimulus(36'h000000001, ca);
    checkOutput("unit_msg", 64'(ca), 64'h000000001793CAC);

    for (int n = 0; n < 12; n++) begin
      ma = 36'({$urandom(), $urandom()});
      applyStimulus(ma, ca);
      checkOutput("random_vs_model", 64'(ca), 64'(refEncode(ma)));
      checkOutput("random_syndromes", 64'(badSyndromes(ca)), 64'd0);
    end

    for (int n = 0; n < 3; n++) begin
      ma = 36'({$urandom(), $urandom()});
      mb = 36'({$urandom(), $urandom()});
      applyStimulus(ma, ca);
      applyStimulus(mb, cb);
      applyStimulus(ma ^ mb, cab);
      checkOutput("linearity", 64'(cab), 64'(ca ^ cb));
    end

    // Second request edge at E3 while busy must be dropped.
    ma = 36'h123456789;
    mb = 36'hFEDCBA987;
    pulses_before = done_pulses;
    @(posedge clk); #1;
    messageIn     = ma;
    encodeMessage = 1'b1;
    @(posedge clk); #1;
    encodeMessage = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    messageIn     = mb;
    encodeMessage = 1'b1;
    repeat (20) @(posedge clk);
    #1 encodeMessage = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("busy_edge_pulses", 64'(done_pulses - pulses_before), 64'd1);
    checkOutput("busy_edge_cw", 64'(codeWordOut), 64'(refEncode(ma)));

    // Reset at E5 aborts the encode without a done pulse.
    pulses_before = done_pulses;
    @(posedge clk); #1;
    messageIn     = 36'h0A5A5A5A5;
    encodeMessage = 1'b1;
    @(posedge clk); #1;
    encodeMessage = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_cw", 64'(codeWordOut), 64'd0);
    checkOutput("abort_busy", 64'(encoderBusy), 64'd0);
    checkOutput("abort_done", 64'(encodeDone), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 64'(done_pulses - pulses_before), 64'd0);
    ma = 36'h987654321;
    applyStimulus(ma, ca);
    checkOutput("after_abort", 64'(ca), 64'(refEncode(ma)));

    // Held request triggers once; message change at E2 is ignored.
    ma = 36'h00FF00FF0;
    mb = 36'hF00FF00FF;
    pulses_before = done_pulses;
    @(posedge clk); #1;
    messageIn     = ma;
    encodeMessage = 1'b1;
    repeat (3) @(posedge clk);
    #1 messageIn = mb;
    repeat (27) @(posedge clk);
    #1 encodeMessage = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("held_pulses", 64'(done_pulses - pulses_before), 64'd1);
    checkOutput("held_cw", 64'(codeWordOut), 64'(refEncode(ma)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
